// File: rtl/moving_average_window.sv
// Signed moving-average filter over a 2**LOG2_DEPTH sample ring buffer, 1-cycle result latency.
// Define MOVAVG_ROUND_EN for round-half-up averaging; default build truncates toward -inf.
module moving_average_window #(
  parameter int W          = 8,
  parameter int LOG2_DEPTH = 2
) (
  input  logic                system1000,
  input  logic                system1000_rstn,
  input  logic                clr,
  input  logic                in_valid,
  input  logic signed [W-1:0] eta_i1,
  output logic                out_valid,
  output logic signed [W-1:0] y_o,
  output logic                full
);

  localparam int N  = 1 << LOG2_DEPTH;
  localparam int SW = W + LOG2_DEPTH;
  localparam logic [LOG2_DEPTH:0] FILL_MAX = (LOG2_DEPTH + 1)'(N);

  logic signed [W-1:0]      r_buf [N];
  logic signed [SW-1:0]     r_sum;
  logic [LOG2_DEPTH-1:0]    r_wr_ptr;
  logic [LOG2_DEPTH:0]      r_fill;
  logic                     r_full;
  logic                     r_out_valid;
  logic signed [W-1:0]      r_y;

  logic signed [W-1:0]      w_old;
  logic signed [SW-1:0]     w_sum_next;
  logic signed [SW-1:0]     w_sum_rnd;
  logic [LOG2_DEPTH:0]      w_fill_next;

  always_comb begin
    w_old      = r_buf[r_wr_ptr];
    w_sum_next = r_sum + {{LOG2_DEPTH{eta_i1[W-1]}}, eta_i1}
                       - {{LOG2_DEPTH{w_old[W-1]}}, w_old};
`ifdef MOVAVG_ROUND_EN
    // Bias by half an LSB of the quotient; the shift below then rounds half up.
    w_sum_rnd  = w_sum_next + SW'(N / 2);
`else
    w_sum_rnd  = w_sum_next;
`endif
    w_fill_next = (r_fill == FILL_MAX) ? r_fill : r_fill + 1'b1;
  end

  always_ff @(posedge system1000 or negedge system1000_rstn) begin
    if (!system1000_rstn) begin
      for (int unsigned i = 0; i < N; i++) r_buf[i] <= '0;
      r_sum       <= '0;
      r_wr_ptr    <= '0;
      r_fill      <= '0;
      r_full      <= 1'b0;
      r_out_valid <= 1'b0;
      r_y         <= '0;
    end else if (clr) begin
      for (int unsigned i = 0; i < N; i++) r_buf[i] <= '0;
      r_sum       <= '0;
      r_wr_ptr    <= '0;
      r_fill      <= '0;
      r_full      <= 1'b0;
      r_out_valid <= 1'b0;
      r_y         <= '0;
    end else if (in_valid) begin
      r_buf[r_wr_ptr] <= eta_i1;
      r_sum           <= w_sum_next;
      r_wr_ptr        <= r_wr_ptr + 1'b1;
      r_fill          <= w_fill_next;
      r_full          <= (w_fill_next == FILL_MAX);
      r_out_valid     <= 1'b1;
      r_y             <= W'(w_sum_rnd >>> LOG2_DEPTH);
    end else begin
      r_out_valid <= 1'b0;
    end
  end

  assign out_valid = r_out_valid;
  assign y_o       = r_y;
  assign full      = r_full;

endmodule
